// File: rtl/smi_req_type_router_pkg.sv
// Shared definitions for the SMI request router: frame type ID bytes, FSM state
// encoding and the header-byte decoder used to pick a destination port.
package smi_req_type_router_pkg;

  localparam logic [7:0] READ_REQ_ID_BYTE   = 8'h01;
  localparam logic [7:0] WRITE_REQ_ID_BYTE  = 8'h02;
  localparam logic [7:0] WRITE_RESP_ID_BYTE = 8'hFE;

  typedef enum logic [1:0] {
    Header  = 2'd0,
    RouteRd = 2'd1,
    RouteWr = 2'd2,
    Discard = 2'd3
  } routerStateT;

  typedef enum logic [1:0] {
    TgtRd   = 2'd0,
    TgtWr   = 2'd1,
    TgtDrop = 2'd2
  } routeTgtT;

  // Write responses never travel on the request channel, so they are dropped.
  function automatic routeTgtT decodeTarget(input logic [7:0] idByte);
    case (idByte)
      READ_REQ_ID_BYTE:   return TgtRd;
      WRITE_REQ_ID_BYTE:  return TgtWr;
      WRITE_RESP_ID_BYTE: return TgtDrop;
      default:            return TgtDrop;
    endcase
  endfunction

endpackage

// File: rtl/smi_skid_buffer.sv
// Two-entry SMI skid buffer: 1 flit/cycle throughput, 1-cycle latency, and an
// upstream stop driven purely from the registered full flag.
module smi_skid_buffer #(
  parameter int Width = 72
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             inReady,
  input  logic [Width-1:0] inData,
  output logic             inStop,
  output logic             outReady,
  output logic [Width-1:0] outData,
  input  logic             outStop
);

  logic [Width-1:0] entryReg [2];
  logic             wrPtrReg;
  logic             rdPtrReg;
  logic [1:0]       countReg;
  logic             push;
  logic             pop;

  assign push     = inReady && !countReg[1];
  assign pop      = (countReg != 2'd0) && !outStop;
  assign inStop   = countReg[1];
  assign outReady = (countReg != 2'd0);
  assign outData  = entryReg[rdPtrReg];

  always_ff @(posedge clk) begin
    if (srst) begin
      wrPtrReg <= 1'b0;
      rdPtrReg <= 1'b0;
      countReg <= 2'd0;
    end else begin
      if (push) wrPtrReg <= ~wrPtrReg;
      if (pop)  rdPtrReg <= ~rdPtrReg;
      case ({push, pop})
        2'b10:   countReg <= countReg + 2'd1;
        2'b01:   countReg <= countReg - 2'd1;
        default: countReg <= countReg;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) entryReg[wrPtrReg] <= inData;
  end

endmodule

// File: rtl/smi_req_type_router.sv
// Routes SMI request frames to the read or write port by header byte 0, dropping
// unknown frames. Define SMI_REQ_ROUTER_DROP_COUNT_EN to add the dropCount output.
module smi_req_type_router
  import smi_req_type_router_pkg::*;
#(
  parameter int DataIndexSize = 3,
  parameter int DataWidth     = (1 << DataIndexSize) * 8
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 smiReqReady,
  input  logic [7:0]           smiReqEofc,
  input  logic [DataWidth-1:0] smiReqData,
  output logic                 smiReqStop,
  output logic                 smiRdReady,
  output logic [7:0]           smiRdEofc,
  output logic [DataWidth-1:0] smiRdData,
  input  logic                 smiRdStop,
  output logic                 smiWrReady,
  output logic [7:0]           smiWrEofc,
  output logic [DataWidth-1:0] smiWrData,
  input  logic                 smiWrStop
`ifdef SMI_REQ_ROUTER_DROP_COUNT_EN
  ,
  output logic [15:0]          dropCount
`endif
);

  localparam int FlitWidth = 8 + DataWidth;

  routerStateT          stateReg;
  routerStateT          stateNext;
  routeTgtT             hdrTgt;
  routeTgtT             curTgt;
  logic                 rdFull;
  logic                 wrFull;
  logic                 accept;
  logic                 lastFlit;
  logic                 rdPush;
  logic                 wrPush;
  logic [FlitWidth-1:0] inFlit;
  logic [FlitWidth-1:0] rdFlit;
  logic [FlitWidth-1:0] wrFlit;

  assign hdrTgt   = decodeTarget(smiReqData[7:0]);
  assign lastFlit = (smiReqEofc != 8'd0);
  assign inFlit   = {smiReqEofc, smiReqData};

  // In Header the live byte 0 picks the target; mid-frame the state holds it.
  always_comb begin
    curTgt = hdrTgt;
    case (stateReg)
      RouteRd: curTgt = TgtRd;
      RouteWr: curTgt = TgtWr;
      Discard: curTgt = TgtDrop;
      default: curTgt = hdrTgt;
    endcase
  end

  always_comb begin
    smiReqStop = 1'b0;
    case (curTgt)
      TgtRd:   smiReqStop = rdFull;
      TgtWr:   smiReqStop = wrFull;
      default: smiReqStop = 1'b0;
    endcase
  end

  assign accept = smiReqReady && !smiReqStop;
  assign rdPush = accept && (curTgt == TgtRd);
  assign wrPush = accept && (curTgt == TgtWr);

  always_ff @(posedge clk) begin
    if (srst) stateReg <= Header;
    else      stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    if (accept) begin
      if (stateReg == Header) begin
        if (!lastFlit) begin
          case (hdrTgt)
            TgtRd:   stateNext = RouteRd;
            TgtWr:   stateNext = RouteWr;
            default: stateNext = Discard;
          endcase
        end
      end else if (lastFlit) begin
        stateNext = Header;
      end
    end
  end

  smi_skid_buffer #(.Width(FlitWidth)) u_rdBuf (
    .clk      (clk),
    .srst     (srst),
    .inReady  (rdPush),
    .inData   (inFlit),
    .inStop   (rdFull),
    .outReady (smiRdReady),
    .outData  (rdFlit),
    .outStop  (smiRdStop)
  );

  smi_skid_buffer #(.Width(FlitWidth)) u_wrBuf (
    .clk      (clk),
    .srst     (srst),
    .inReady  (wrPush),
    .inData   (inFlit),
    .inStop   (wrFull),
    .outReady (smiWrReady),
    .outData  (wrFlit),
    .outStop  (smiWrStop)
  );

  assign {smiRdEofc, smiRdData} = rdFlit;
  assign {smiWrEofc, smiWrData} = wrFlit;

`ifdef SMI_REQ_ROUTER_DROP_COUNT_EN
  logic [15:0] dropCountReg;

  // One count per dropped frame, taken on its closing flit, saturating.
  always_ff @(posedge clk) begin
    if (srst) begin
      dropCountReg <= 16'd0;
    end else if (accept && lastFlit && (curTgt == TgtDrop) && (dropCountReg != 16'hFFFF)) begin
      dropCountReg <= dropCountReg + 16'd1;
    end
  end

  assign dropCount = dropCountReg;
`endif

endmodule

// File: doc/smi_req_type_router.md
SMI_REQ_TYPE_ROUTER -- requirements
Module: smi_req_type_router

Interface
REQ-001 SHALL have parameter DataIndexSize, default 3, meaning log2 of data bytes per flit (valid range 3..6).
REQ-002 SHALL have parameter DataWidth, default (1<<DataIndexSize)*8, meaning flit data width in bits.
REQ-003 SHALL have ports: clk  in  1  clock; srst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: smiReqReady  in  1  inbound flit valid; smiReqEofc  in  8  end-of-frame byte count (0 = mid-frame); smiReqData  in  DataWidth  flit data; smiReqStop  out  1  inbound backpressure.
REQ-005 SHALL have ports: smiRdReady  out  1; smiRdEofc  out  8; smiRdData  out  DataWidth; smiRdStop  in  1.
REQ-006 SHALL have ports: smiWrReady  out  1; smiWrEofc  out  8; smiWrData  out  DataWidth; smiWrStop  in  1.

Function
REQ-007 SHALL transfer a flit on any SMI port only in a cycle where Ready=1 and Stop=0.
REQ-008 SHALL classify each frame by byte 0 of its first flit: 8'h01 = read request, 8'h02 = write request, any other value = unknown.
REQ-009 SHALL use FSM states Header, RouteRd, RouteWr, Discard; reset state is Header.
REQ-010 In Header, accepting a first flit with Eofc=0 SHALL move the FSM to RouteRd, RouteWr or Discard by type; with Eofc!=0 the FSM SHALL stay in Header.
REQ-011 In RouteRd, RouteWr or Discard, accepting a flit with Eofc!=0 SHALL return the FSM to Header.
REQ-012 SHALL forward every flit of a read or write frame, header flit included, unmodified (Eofc and Data) to the selected port.
REQ-013 SHALL accept and silently drop every flit of an unknown frame, with smiReqStop=0 for those flits.
REQ-014 SHALL give each output port a 2-entry skid buffer: full throughput of 1 flit/cycle, 1-cycle latency from input acceptance to output Ready.
REQ-015 smiReqStop SHALL equal the full flag of the buffer selected by the current flit (Header state: decoded from the live data; Route states: locked selection).
REQ-016 SHALL compute smiReqStop only from registered state and current input data, with no path from smiRdStop or smiWrStop.
REQ-017 A stall on one output SHALL stall the input only while the in-progress or next frame targets that output.
REQ-018 Frame order SHALL be preserved per output; no ordering guarantee applies across outputs.

Reset
REQ-019 On srst SHALL reset: FSM to Header, both skid buffers to empty, smiRdReady=0, smiWrReady=0, smiReqStop=0, drop counter to 0.
REQ-020 Reset mid-frame SHALL abandon the partial frame; the next flit after reset SHALL be treated as a header.
REQ-021 Datapath registers (Eofc, Data) SHALL be non-resettable.

Configuration
REQ-022 With SMI_REQ_ROUTER_DROP_COUNT_EN defined, the block SHALL add output dropCount (out, 16 bits).
REQ-023 dropCount SHALL increment once per discarded frame, on acceptance of the flit with Eofc!=0, and SHALL saturate at 16'hFFFF.
REQ-024 With SMI_REQ_ROUTER_DROP_COUNT_EN undefined, the port and the counter SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-025 The shared package SHALL hold the frame type constants (READ_REQ_ID_BYTE 8'h01, WRITE_REQ_ID_BYTE 8'h02, WRITE_RESP_ID_BYTE 8'hFE) and the FSM state encoding.
REQ-026 The skid buffer SHALL be a sub-module, smi_skid_buffer, parameterised by width (8+DataWidth) and instantiated twice.

Verification
REQ-027 3-flit frame, byte0=8'h02, Eofc 0,0,8 -> the same 3 flits on smiWr* one cycle later; smiRdReady stays 0.
REQ-028 1-flit frame, byte0=8'h01, Eofc=8 -> one flit on smiRd*; FSM remains in Header.
REQ-029 Frame with byte0=8'h7F, 4 flits -> nothing output; smiReqStop=0 throughout; dropCount 0->1 when macro defined.
REQ-030 smiWrStop=1 held for 10 cycles during a write frame -> input stalls after 2 buffered flits; a following read frame still passes only after the write frame completes; no flit lost or duplicated.
REQ-031 srst asserted after the 2nd flit of a 5-flit write frame -> outputs Ready=0 next cycle; the next frame byte0=8'h01 routes to Rd.
REQ-032 Back-to-back Rd/Wr/Rd frames, Stops=0 -> 1 flit/cycle sustained, with correct per-port contents.
